dpd_mag_addr_gen: RTL and testbench

DPD_MAG_ADDR_GEN -- requirements
Module: dpd_mag_addr_gen

---
 rtl/dpd_mag_addr_gen_if.sv | 24 ++
 rtl/dpd_mag_addr_gen.sv | 128 ++++++++++++
 tb/tb_dpd_mag_addr_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dpd_mag_addr_gen_if.sv
// rtl/dpd_mag_addr_gen_if.sv - sample in / tap-pair out bundle for the DPD LUT address generator
// Master drives samples and controls; slave (the generator) returns the tap pair and addresses.
interface dpd_mag_addr_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    x_valid;
  logic [DATA_WIDTH-1:0]   x;
  logic [4:0]              mag_shift;
  logic                    clear;
  logic                    tu_enable;
  logic [2*DATA_WIDTH-1:0] tu;
  logic [2*ADDR_WIDTH-1:0] mag;

  modport master (
    output x_valid, x, mag_shift, clear,
    input  tu_enable, tu, mag
  );

  modport slave (
    input  x_valid, x, mag_shift, clear,
    output tu_enable, tu, mag
  );
endinterface

// File: rtl/dpd_mag_addr_gen.sv
// rtl/dpd_mag_addr_gen.sv - |x|^2 to saturated LUT address, paired with the previous sample
// Four register levels: squares, power, shifted/saturated address, output with history.
module dpd_mag_addr_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dpd_mag_addr_gen_if.slave        bus
);
  localparam int HW = DATA_WIDTH / 2;
  localparam logic [DATA_WIDTH-1:0] SAT_LIMIT = DATA_WIDTH'((1 << ADDR_WIDTH) - 1);

  logic                    v1_q, v1_d;
  logic [DATA_WIDTH-1:0]   x1_q, x1_d;
  logic [DATA_WIDTH-1:0]   sq_i_q, sq_i_d;
  logic [DATA_WIDTH-1:0]   sq_q_q, sq_q_d;
  logic                    v2_q, v2_d;
  logic [DATA_WIDTH-1:0]   x2_q, x2_d;
  logic [DATA_WIDTH-1:0]   pwr_q, pwr_d;
  logic                    v3_q, v3_d;
  logic [DATA_WIDTH-1:0]   x3_q, x3_d;
  logic [ADDR_WIDTH-1:0]   addr3_q, addr3_d;
  logic [DATA_WIDTH-1:0]   hist_x_q, hist_x_d;
  logic [ADDR_WIDTH-1:0]   hist_a_q, hist_a_d;
  logic                    tu_enable_q, tu_enable_d;
  logic [2*DATA_WIDTH-1:0] tu_q, tu_d;
  logic [2*ADDR_WIDTH-1:0] mag_q, mag_d;

  logic signed [DATA_WIDTH-1:0] i_ext, q_ext, i_sq, q_sq;
  logic        [DATA_WIDTH-1:0] shifted;

  always_comb begin
    // Sign-extend before multiplying so the full-scale square (2^(DW-2)) is exact.
    i_ext = signed'({{HW{bus.x[HW-1]}}, bus.x[HW-1:0]});
    q_ext = signed'({{HW{bus.x[DATA_WIDTH-1]}}, bus.x[DATA_WIDTH-1:HW]});
    i_sq  = i_ext * i_ext;
    q_sq  = q_ext * q_ext;

    v1_d   = bus.x_valid & ~bus.clear;
    x1_d   = x1_q;
    sq_i_d = sq_i_q;
    sq_q_d = sq_q_q;
    if (v1_d) begin
      x1_d   = bus.x;
      sq_i_d = DATA_WIDTH'(i_sq);
      sq_q_d = DATA_WIDTH'(q_sq);
    end

    v2_d  = v1_q & ~bus.clear;
    x2_d  = x2_q;
    pwr_d = pwr_q;
    if (v1_q) begin
      x2_d  = x1_q;
      pwr_d = sq_i_q + sq_q_q;
    end

    if (32'(bus.mag_shift) >= 32'(DATA_WIDTH)) begin
      shifted = '0;
    end else begin
      shifted = pwr_q >> bus.mag_shift;
    end

    v3_d    = v2_q & ~bus.clear;
    x3_d    = x3_q;
    addr3_d = addr3_q;
    if (v2_q) begin
      x3_d    = x2_q;
      addr3_d = (shifted > SAT_LIMIT) ? {ADDR_WIDTH{1'b1}} : shifted[ADDR_WIDTH-1:0];
    end

    // tu/mag only move on an emitted sample; clear zeroes history but leaves them holding.
    tu_enable_d = v3_q & ~bus.clear;
    tu_d        = tu_q;
    mag_d       = mag_q;
    hist_x_d    = hist_x_q;
    hist_a_d    = hist_a_q;
    if (bus.clear) begin
      hist_x_d = '0;
      hist_a_d = '0;
    end else if (v3_q) begin
      tu_d     = {hist_x_q, x3_q};
      mag_d    = {hist_a_q, addr3_q};
      hist_x_d = x3_q;
      hist_a_d = addr3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      x1_q        <= '0;
      sq_i_q      <= '0;
      sq_q_q      <= '0;
      v2_q        <= 1'b0;
      x2_q        <= '0;
      pwr_q       <= '0;
      v3_q        <= 1'b0;
      x3_q        <= '0;
      addr3_q     <= '0;
      hist_x_q    <= '0;
      hist_a_q    <= '0;
      tu_enable_q <= 1'b0;
      tu_q        <= '0;
      mag_q       <= '0;
    end else begin
      v1_q        <= v1_d;
      x1_q        <= x1_d;
      sq_i_q      <= sq_i_d;
      sq_q_q      <= sq_q_d;
      v2_q        <= v2_d;
      x2_q        <= x2_d;
      pwr_q       <= pwr_d;
      v3_q        <= v3_d;
      x3_q        <= x3_d;
      addr3_q     <= addr3_d;
      hist_x_q    <= hist_x_d;
      hist_a_q    <= hist_a_d;
      tu_enable_q <= tu_enable_d;
      tu_q        <= tu_d;
      mag_q       <= mag_d;
    end
  end

  assign bus.tu_enable = tu_enable_q;
  assign bus.tu        = tu_q;
  assign bus.mag       = mag_q;
endmodule

// File: tb/tb_dpd_mag_addr_gen.sv
// tb/tb_dpd_mag_addr_gen.sv - directed vector bench for dpd_mag_addr_gen
// Isolated-sample table plus hand sequences for streaming, bubbles, clear and async reset.
module tb_dpd_mag_addr_gen;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dpd_mag_addr_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  dpd_mag_addr_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [4:0]  sh;
    logic [3:0]  addr;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] sx[6];
  logic [3:0]  sa[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.x_valid   = 1'b0;
    bus.x         = '0;
    bus.mag_shift = '0;
    bus.clear     = 1'b0;

    // {x, mag_shift, expected addr} for samples sent alone after a clear
    vecs[0] = '{32'h0003_0004, 5'd0,  4'd15};
    vecs[1] = '{32'h8000_8000, 5'd31, 4'd1};
    vecs[2] = '{32'h8000_8000, 5'd0,  4'd15};
    vecs[3] = '{32'hFFFF_0002, 5'd0,  4'd5};
    vecs[4] = '{32'h0000_0100, 5'd12, 4'd15};
    vecs[5] = '{32'h0000_0100, 5'd13, 4'd8};
    vecs[6] = '{32'h7FFF_7FFF, 5'd28, 4'd7};
    vecs[7] = '{32'h0000_FFFD, 5'd0,  4'd9};

    #12;
    chk("reset_en",  {63'd0, bus.tu_enable}, 64'd0);
    chk("reset_tu",  bus.tu, 64'd0);
    chk("reset_mag", {56'd0, bus.mag}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      pulse_clear();
      bus.mag_shift = vecs[v].sh;
      bus.x         = vecs[v].x;
      bus.x_valid   = 1'b1;
      tick();
      bus.x_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_early", v), {63'd0, bus.tu_enable}, 64'd0);
      tick();
      tick();
      chk($sformatf("vec%0d_en", v),  {63'd0, bus.tu_enable}, 64'd1);
      chk($sformatf("vec%0d_tu", v),  bus.tu, {32'd0, vecs[v].x});
      chk($sformatf("vec%0d_mag", v), {56'd0, bus.mag}, {60'd0, vecs[v].addr});
      tick();
      chk($sformatf("vec%0d_once", v), {63'd0, bus.tu_enable}, 64'd0);
    end

    // Back-to-back ramp I=0..5, Q=0, shift 1
    sa[0] = 4'd0; sa[1] = 4'd0; sa[2] = 4'd2; sa[3] = 4'd4; sa[4] = 4'd8; sa[5] = 4'd12;
    for (int i = 0; i < 6; i++) sx[i] = 32'(i);
    pulse_clear();
    bus.mag_shift = 5'd1;
    for (int t = 0; t < 10; t++) begin
      bus.x_valid = (t < 6);
      bus.x       = 32'(t);
      tick();
      if (t >= 3 && t <= 8) begin
        chk($sformatf("ramp%0d_en", t - 3), {63'd0, bus.tu_enable}, 64'd1);
        chk($sformatf("ramp%0d_tu", t - 3), bus.tu,
            {(t == 3) ? 32'd0 : sx[t-4], sx[t-3]});
        chk($sformatf("ramp%0d_mag", t - 3), {56'd0, bus.mag},
            {56'd0, (t == 3) ? 4'd0 : sa[t-4], sa[t-3]});
      end else begin
        chk($sformatf("ramp_idle%0d", t), {63'd0, bus.tu_enable}, 64'd0);
      end
    end

    // A, bubble, B: A={1,2} -> 5, B={0,3} -> 9
    pulse_clear();
    bus.mag_shift = 5'd0;
    bus.x = 32'h0001_0002; bus.x_valid = 1'b1; tick();
    bus.x_valid = 1'b0; tick();
    bus.x = 32'h0000_0003; bus.x_valid = 1'b1; tick();
    bus.x_valid = 1'b0; tick();
    chk("bub_a_en",  {63'd0, bus.tu_enable}, 64'd1);
    chk("bub_a_tu",  bus.tu, 64'h0000_0000_0001_0002);
    chk("bub_a_mag", {56'd0, bus.mag}, 64'h05);
    tick();
    chk("bub_idle_en",  {63'd0, bus.tu_enable}, 64'd0);
    chk("bub_idle_tu",  bus.tu, 64'h0000_0000_0001_0002);
    chk("bub_idle_mag", {56'd0, bus.mag}, 64'h05);
    tick();
    chk("bub_b_en",  {63'd0, bus.tu_enable}, 64'd1);
    chk("bub_b_tu",  bus.tu, 64'h0001_0002_0000_0003);
    chk("bub_b_mag", {56'd0, bus.mag}, 64'h59);

    // Two samples in flight, clear, then C={0,1} -> 1 with zero history
    bus.x = 32'h0000_0007; bus.x_valid = 1'b1; tick();
    bus.x = 32'h0000_0006; tick();
    bus.clear = 1'b1; bus.x = 32'h0000_0005; tick();
    bus.clear = 1'b0;
    bus.x = 32'h0000_0001; bus.x_valid = 1'b1; tick();
    chk("clr_flush0", {63'd0, bus.tu_enable}, 64'd0);
    chk("clr_hold_tu", bus.tu, 64'h0001_0002_0000_0003);
    bus.x_valid = 1'b0; tick();
    chk("clr_flush1", {63'd0, bus.tu_enable}, 64'd0);
    tick();
    chk("clr_flush2", {63'd0, bus.tu_enable}, 64'd0);
    tick();
    chk("clr_c_en",  {63'd0, bus.tu_enable}, 64'd1);
    chk("clr_c_tu",  bus.tu, 64'h0000_0000_0000_0001);
    chk("clr_c_mag", {56'd0, bus.mag}, 64'h01);

    // Async reset between edges with samples in flight
    bus.x = 32'h0000_0002; bus.x_valid = 1'b1; tick();
    bus.x = 32'h0000_0003; tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_en",  {63'd0, bus.tu_enable}, 64'd0);
    chk("rst_async_tu",  bus.tu, 64'd0);
    chk("rst_async_mag", {56'd0, bus.mag}, 64'd0);
    bus.x_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rst_drop%0d", t), {63'd0, bus.tu_enable}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
